serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial A − B − Bin engine; the subtraction counterpart to the library's parallel carry-chain adders.
- Holds one borrow flip-flop and resolves one bit per clock, LSB first.
- Area-lean subtract path for datapaths that can tolerate WIDTH-cycle latency.
- start/busy/done handshake; result registered and held until the next operation completes.

Parameters:
WIDTH, 4, operand and result width in bits (≥2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
A  input  WIDTH  minuend; captured on accepted start
B  input  WIDTH  subtrahend; captured on accepted start
Bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: Diff/Bout just updated
Diff  output  WIDTH  A − B − Bin mod 2^WIDTH
Bout  output  1  final borrow-out (1 ⇔ A < B + Bin, unsigned)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, Diff=0, Bout=0; internal shift registers, borrow FF and bit counter cleared.
- Reset mid-operation: the operation is aborted immediately. No done pulse follows. Outputs return to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - latch A, B and Bin (Bin into the borrow FF);
  - clear the bit counter;
  - go to RUN.
- RUN (busy=1): each edge processes bit i = counter.
  - d = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d shifts into the result shift register (LSB first); the operand registers shift right; the counter increments.
  - After the edge processing bit WIDTH−1, go to DONE and load Diff (full result) and Bout (= br_next) in the same edge.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back, next state RUN).
  - Otherwise go to IDLE.
- Latency: start sampled at edge k → busy=1 from edge k to edge k+WIDTH → done=1 for the cycle after edge k+WIDTH. Throughput: one op per WIDTH+1 cycles.
- start while busy=1: ignored; it does not affect the operation in flight.
- Diff/Bout change only at the DONE-entry edge and hold otherwise. Intermediate bits are never visible on Diff.
- A, B and Bin may change freely after an accepted start.
- Arithmetic: unsigned, modulo 2^WIDTH; all-ones − all-ones and 0 − 0 are legal.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Add output port ovf (1 bit, reset 0), updated with Diff at DONE entry and held otherwise.
  - ovf = 1 when the two's-complement signed result overflows, i.e. (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]).
  - Sign bits are taken from the latched operands.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Test Plan:
- WIDTH=4, A=9, B=3, Bin=0, start one cycle → busy for 4 cycles, then done pulse with Diff=6, Bout=0.
- WIDTH=4, A=3, B=9, Bin=0 → Diff=4'b1010, Bout=1; Diff held after done until the next completion.
- WIDTH=4, A=0, B=0, Bin=1 → Diff=4'b1111, Bout=1. Then, back-to-back, start asserted in the DONE cycle with A=15, B=15, Bin=0 → second done exactly 5 cycles after the first, with Diff=0, Bout=0.
- Start at A=5, B=2; pulse start again with A=1, B=7 on the 2nd RUN cycle → the second start is ignored; done gives Diff=3, Bout=0, and only one done pulse occurs.
- Start A=12, B=4; deassert rst_n on the 2nd RUN cycle → busy, done, Diff and Bout drop to 0 immediately. After release, no done occurs until a new start.
- SERIAL_SUB_OVF_EN, WIDTH=4, A=4'b1000, B=4'b0001 → Diff=4'b0111, Bout=0, ovf=1. With WIDTH=8, A=200, B=55 → Diff=145, Bout=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin engine: one borrow flip-flop, one bit per clock, LSB first.
// Optional signed-overflow flag output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, diff_reg;
    logic [CW-1:0]    cnt_reg;
    logic             br_reg, bout_reg;
    logic             accept, last_bit, bit_d, br_next;

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));
    assign bit_d    = a_reg[0] ^ b_reg[0] ^ br_reg;
    assign br_next  = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A start in the DONE cycle chains the next operation with no idle gap.
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else if (accept) begin
            a_reg   <= A;
            b_reg   <= B;
            br_reg  <= Bin;
            cnt_reg <= '0;
            res_reg <= '0;
        end else if (state_reg == RUN) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            br_reg  <= br_next;
            res_reg <= {bit_d, res_reg[WIDTH-1:1]};
            cnt_reg <= cnt_reg + 1'b1;
            if (last_bit) begin
                diff_reg <= {bit_d, res_reg[WIDTH-1:1]};
                bout_reg <= br_next;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_reg;

    // On the last bit, a_reg[0]/b_reg[0] are the latched sign bits and bit_d is the result sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (!accept && state_reg == RUN && last_bit) begin
            ovf_reg <= (a_reg[0] != b_reg[0]) && (bit_d != a_reg[0]);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign Diff = diff_reg;
    assign Bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a 4-bit and an 8-bit instance on one clock.
// Expected results are pushed when an operation is started and popped on its done pulse.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n, start, bin, start8, bin8;
    logic [3:0] a, b, diff;
    logic [7:0] a8, b8, diff8;
    logic       busy, done, bout, busy8, done8, bout8;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf, ovf8;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    exp_t sb4[$];
    exp_t sb8[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Bin(bin),
        .busy(busy), .done(done), .Diff(diff), .Bout(bout)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .Diff(diff8), .Bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    function automatic exp_t model(input int w, input int av, input int bv, input int binv);
        exp_t e;
        int   mask;
        int   res;
        mask   = (1 << w) - 1;
        res    = (av - bv - binv) & mask;
        e.diff = 8'(res);
        e.bout = (av < bv + binv);
        e.ovf  = (((av >> (w - 1)) & 1) != ((bv >> (w - 1)) & 1)) &&
                 (((res >> (w - 1)) & 1) != ((av >> (w - 1)) & 1));
        return e;
    endfunction

    // Caller is 1 time unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic go4(input int av, input int bv, input int binv, input bit push);
        a = 4'(av); b = 4'(bv); bin = 1'(binv); start = 1'b1;
        if (push) sb4.push_back(model(4, av, bv, binv));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic go8(input int av, input int bv, input int binv);
        a8 = 8'(av); b8 = 8'(bv); bin8 = 1'(binv); start8 = 1'b1;
        sb8.push_back(model(8, av, bv, binv));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait4(input int budget, output int cycles, output bit seen);
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < budget) begin
            if (done) seen = 1'b1;
            else begin @(posedge clk); #1; cycles++; end
        end
    endtask

    task automatic wait8(input int budget, output int cycles, output bit seen);
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < budget) begin
            if (done8) seen = 1'b1;
            else begin @(posedge clk); #1; cycles++; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1; start = 1'b0; start8 = 1'b0;
        a = '0; b = '0; bin = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if ({busy, done, diff, bout} !== 7'b0) begin
            errors++; $display("FAIL reset4: got busy=%b done=%b diff=%h bout=%b, want all 0", busy, done, diff, bout);
        end
        checks++; if ({busy8, done8, diff8, bout8} !== 11'b0) begin
            errors++; $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8, bout8);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if ({ovf, ovf8} !== 2'b00) begin
            errors++; $display("FAIL reset_ovf: got %b%b, want 00", ovf, ovf8);
        end
`endif
        start = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_start_held: busy=%b, want 0", busy);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: outputs cleared");
    endtask

    task automatic test_basic;
        int cyc; bit seen; exp_t e;
        go4(9, 3, 0, 1'b1);
        checks++; if (busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: busy=%b, want 1", busy);
        end
        wait4(10, cyc, seen);
        checks++; if (!seen || cyc != 4) begin
            errors++; $display("FAIL basic_latency: seen=%0b cycles=%0d, want done after 4", seen, cyc);
        end
        if (seen) begin
            e = sb4.pop_front();
            checks++; if (diff !== e.diff[3:0] || bout !== e.bout || busy !== 1'b0) begin
                errors++; $display("FAIL basic_result: diff=%0d bout=%b busy=%b, want diff=%0d bout=%b busy=0", diff, bout, busy, e.diff[3:0], e.bout);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++; if (ovf !== e.ovf) begin
                errors++; $display("FAIL basic_ovf: got %b want %b", ovf, e.ovf);
            end
`endif
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || diff !== 4'd6) begin
            errors++; $display("FAIL basic_pulse: done=%b diff=%0d, want done=0 diff=6", done, diff);
        end
        $display("op 9-3-0: Diff=%0d Bout=%b", diff, bout);
    endtask

    task automatic test_hold;
        int cyc; bit seen; exp_t e;
        go4(3, 9, 0, 1'b1);
        wait4(10, cyc, seen);
        checks++; if (!seen) begin
            errors++; $display("FAIL hold_timeout: no done within 10 cycles, want done");
        end else begin
            e = sb4.pop_front();
            checks++; if (diff !== e.diff[3:0] || bout !== e.bout) begin
                errors++; $display("FAIL hold_result: diff=%b bout=%b, want diff=%b bout=%b", diff, bout, e.diff[3:0], e.bout);
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (diff !== 4'b1010 || bout !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_idle: diff=%b bout=%b done=%b busy=%b, want 1010 1 0 0", diff, bout, done, busy);
        end
        $display("op 3-9-0: Diff=%b Bout=%b held", diff, bout);
    endtask

    task automatic test_back_to_back;
        int cyc1, cyc2; bit seen1, seen2; exp_t e;
        go4(0, 0, 1, 1'b1);
        wait4(10, cyc1, seen1);
        checks++; if (!seen1) begin
            errors++; $display("FAIL b2b_first_timeout: no done within 10 cycles");
        end else begin
            e = sb4.pop_front();
            checks++; if (diff !== e.diff[3:0] || bout !== e.bout) begin
                errors++; $display("FAIL b2b_first: diff=%b bout=%b, want diff=%b bout=%b", diff, bout, e.diff[3:0], e.bout);
            end
        end
        $display("op 0-0-1: Diff=%b Bout=%b", diff, bout);
        go4(15, 15, 0, 1'b1);
        checks++; if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: busy=%b, want 1", busy);
        end
        wait4(10, cyc2, seen2);
        checks++; if (!seen2 || cyc2 + 1 != 5) begin
            errors++; $display("FAIL b2b_gap: seen=%0b gap=%0d, want 5", seen2, cyc2 + 1);
        end
        if (seen2) begin
            e = sb4.pop_front();
            checks++; if (diff !== e.diff[3:0] || bout !== e.bout) begin
                errors++; $display("FAIL b2b_second: diff=%b bout=%b, want diff=%b bout=%b", diff, bout, e.diff[3:0], e.bout);
            end
        end
        $display("op 15-15-0 (back-to-back): Diff=%b Bout=%b", diff, bout);
    endtask

    task automatic test_start_ignored;
        int cyc, dc; bit seen; exp_t e;
        go4(5, 2, 0, 1'b1);
        @(posedge clk); #1;
        a = 4'd1; b = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait4(10, cyc, seen);
        checks++; if (!seen || cyc != 2) begin
            errors++; $display("FAIL ignore_timing: seen=%0b cycles=%0d, want done after 2 more", seen, cyc);
        end
        if (seen) begin
            e = sb4.pop_front();
            checks++; if (diff !== e.diff[3:0] || bout !== e.bout) begin
                errors++; $display("FAIL ignore_result: diff=%0d bout=%b, want diff=%0d bout=%b", diff, bout, e.diff[3:0], e.bout);
            end
        end
        dc = 0;
        repeat (8) begin @(posedge clk); #1; if (done) dc++; end
        checks++; if (dc != 0) begin
            errors++; $display("FAIL ignore_extra_done: got %0d extra done pulses, want 0", dc);
        end
        $display("op 5-2-0 with ignored start: Diff=%0d Bout=%b", diff, bout);
    endtask

    task automatic test_mid_reset;
        int cyc; bit seen;
        go4(12, 4, 0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, diff, bout} !== 7'b0) begin
            errors++; $display("FAIL midreset_clear: busy=%b done=%b diff=%0d bout=%b, want all 0", busy, done, diff, bout);
        end
        void'(sb4.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait4(12, cyc, seen);
        checks++; if (seen || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_no_done: done seen=%0b busy=%b, want none", seen, busy);
        end
        $display("op 12-4-0 aborted by reset: Diff=%0d Bout=%b", diff, bout);
    endtask

    task automatic test_random4;
        int cyc, av, bv, binv; bit seen; exp_t e;
        for (int i = 0; i < 6; i++) begin
            av = int'($urandom_range(15)); bv = int'($urandom_range(15)); binv = int'($urandom_range(1));
            go4(av, bv, binv, 1'b1);
            wait4(10, cyc, seen);
            checks++; if (!seen) begin
                errors++; $display("FAIL rand4_timeout: op %0d-%0d-%0d no done", av, bv, binv);
            end else begin
                e = sb4.pop_front();
                checks++; if (diff !== e.diff[3:0] || bout !== e.bout) begin
                    errors++; $display("FAIL rand4_result: %0d-%0d-%0d diff=%0d bout=%b, want diff=%0d bout=%b", av, bv, binv, diff, bout, e.diff[3:0], e.bout);
                end
`ifdef SERIAL_SUB_OVF_EN
                checks++; if (ovf !== e.ovf) begin
                    errors++; $display("FAIL rand4_ovf: %0d-%0d got %b want %b", av, bv, ovf, e.ovf);
                end
`endif
            end
            $display("op %0d-%0d-%0d: Diff=%0d Bout=%b", av, bv, binv, diff, bout);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wide;
        int cyc, av, bv, binv; bit seen; exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin av = 200; bv = 55; binv = 0; end
            else if (i == 1) begin av = 0; bv = 255; binv = 1; end
            else begin av = int'($urandom_range(255)); bv = int'($urandom_range(255)); binv = int'($urandom_range(1)); end
            go8(av, bv, binv);
            wait8(20, cyc, seen);
            checks++; if (!seen || cyc != 8) begin
                errors++; $display("FAIL wide_latency: seen=%0b cycles=%0d, want 8", seen, cyc);
            end
            if (seen) begin
                e = sb8.pop_front();
                checks++; if (diff8 !== e.diff || bout8 !== e.bout) begin
                    errors++; $display("FAIL wide_result: %0d-%0d-%0d diff=%0d bout=%b, want diff=%0d bout=%b", av, bv, binv, diff8, bout8, e.diff, e.bout);
                end
`ifdef SERIAL_SUB_OVF_EN
                checks++; if (ovf8 !== e.ovf) begin
                    errors++; $display("FAIL wide_ovf: got %b want %b", ovf8, e.ovf);
                end
`endif
            end
            $display("op8 %0d-%0d-%0d: Diff=%0d Bout=%b", av, bv, binv, diff8, bout8);
            @(posedge clk); #1;
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        int cyc; bit seen; exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) go4(8, 1, 0, 1'b1);
            else        go4(2, 1, 0, 1'b1);
            wait4(10, cyc, seen);
            checks++; if (!seen) begin
                errors++; $display("FAIL ovf_timeout: no done");
            end else begin
                e = sb4.pop_front();
                checks++; if (ovf !== e.ovf || diff !== e.diff[3:0] || bout !== e.bout) begin
                    errors++; $display("FAIL ovf_result: diff=%b bout=%b ovf=%b, want diff=%b bout=%b ovf=%b", diff, bout, ovf, e.diff[3:0], e.bout, e.ovf);
                end
            end
            $display("ovf op: Diff=%b Bout=%b ovf=%b", diff, bout, ovf);
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_back_to_back;
        @(posedge clk); #1;
        test_start_ignored;
        test_mid_reset;
        test_random4;
        test_wide;
`ifdef SERIAL_SUB_OVF_EN
        test_ovf;
`endif
        checks++; if (sb4.size() != 0 || sb8.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d/%0d entries left, want 0", sb4.size(), sb8.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
